apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 115 +++++++++++
 tb/tb_apb_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester that turns one local command into a SETUP/ACCESS transfer with a one-cycle response pulse.
// Define APB_MASTER_TIMEOUT_EN to abort transfers stalled in ACCESS for TIMEOUT_CYCLES wait cycles.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0] state;

    // Acceptance is only possible in IDLE, so nothing can be queued behind a live transfer.
    assign cmd_ready = (state == ST_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;

    // The edge that would bring the count to TIMEOUT_CYCLES is the abort edge.
    assign timeout_hit = !PREADY && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            timeout_cnt <= '0;
        end else if (state == ST_SETUP) begin
            timeout_cnt <= '0;
        end else if (state == ST_ACCESS && !PREADY) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, matching real flop behaviour.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state  <= ST_SETUP;
                        PSEL   <= 1'b1;
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        state     <= ST_IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state     <= ST_IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
`endif
                end
                default: begin
                    state   <= ST_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master: reset, write/read, wait states, slave error,
// reset mid-transfer, timeout (or indefinite wait) and back-to-back throughput.
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int rsp_seen;

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        tick();
        tick();

        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        PRESET = 1'b0;
        tick();

        // Zero-wait write: SETUP at T+1, ACCESS at T+2, response at T+3.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'hDEADBEEF;
        PREADY    = 1'b1;
        PRDATA    = 32'h12345678;
        tick();
        check("wr_setup_psel", PSEL, 1);
        check("wr_setup_penable", PENABLE, 0);
        check("wr_setup_pwrite", PWRITE, 1);
        check("wr_setup_paddr", PADDR, 32'h10);
        check("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
        check("wr_setup_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        tick();
        check("wr_access_psel", PSEL, 1);
        check("wr_access_penable", PENABLE, 1);
        check("wr_access_rsp", rsp_valid, 0);
        tick();
        check("wr_done_rsp_valid", rsp_valid, 1);
        check("wr_done_rsp_err", rsp_err, 0);
        check("wr_done_rsp_rdata", rsp_rdata, 0);
        check("wr_done_psel", PSEL, 0);
        check("wr_done_penable", PENABLE, 0);
        check("wr_done_ready", cmd_ready, 1);
        check("wr_idle_paddr_kept", PADDR, 32'h10);
        tick();
        check("wr_pulse_one_cycle", rsp_valid, 0);

        // Read with two wait states: response at T+5.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'h55;
        PREADY    = 1'b0;
        PRDATA    = 32'hDEADBEEF;
        tick();
        check("rd_setup_psel", PSEL, 1);
        check("rd_setup_pwrite", PWRITE, 0);
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF;
        tick();
        check("rd_access_penable", PENABLE, 1);
        check("rd_access_paddr", PADDR, 32'h10);
        tick();
        check("rd_wait1_penable", PENABLE, 1);
        check("rd_wait1_rsp", rsp_valid, 0);
        check("rd_wait1_paddr", PADDR, 32'h10);
        tick();
        check("rd_wait2_penable", PENABLE, 1);
        check("rd_wait2_rsp", rsp_valid, 0);
        check("rd_wait2_paddr", PADDR, 32'h10);
        PREADY = 1'b1;
        tick();
        check("rd_done_rsp_valid", rsp_valid, 1);
        check("rd_done_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_done_rsp_err", rsp_err, 0);
        check("rd_done_psel", PSEL, 0);
        PRDATA = 32'h0;
        tick();
        check("rd_rsp_valid_drop", rsp_valid, 0);
        check("rd_rdata_held", rsp_rdata, 32'hDEADBEEF);

        // Completer error on a read, then an immediate follow-up request from IDLE.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        PREADY    = 1'b1;
        PSLVERR   = 1'b1;
        PRDATA    = 32'hCAFE0001;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("err_rsp_valid", rsp_valid, 1);
        check("err_rsp_err", rsp_err, 1);
        check("err_rsp_rdata", rsp_rdata, 32'hCAFE0001);
        check("err_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h24;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h0BAD0024;
        tick();
        check("err_pulse_one_cycle", rsp_valid, 0);
        check("err_held", rsp_err, 1);
        check("next_setup_psel", PSEL, 1);
        check("next_setup_paddr", PADDR, 32'h24);
        cmd_valid = 1'b0;
        tick();
        tick();
        check("next_rsp_valid", rsp_valid, 1);
        check("next_rsp_err", rsp_err, 0);
        check("next_rsp_rdata", rsp_rdata, 32'h0BAD0024);
        tick();

        // Reset during an ACCESS wait state.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h30;
        cmd_wdata = 32'h77;
        PREADY    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rstmid_in_wait", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        check("rstmid_psel", PSEL, 0);
        check("rstmid_penable", PENABLE, 0);
        check("rstmid_paddr", PADDR, 0);
        check("rstmid_pwdata", PWDATA, 0);
        check("rstmid_pwrite", PWRITE, 0);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_rsp_rdata", rsp_rdata, 0);
        check("rstmid_ready", cmd_ready, 1);
        PRESET = 1'b0;
        PREADY = 1'b1;
        tick();
        check("rstmid_no_rsp", rsp_valid, 0);
        check("rstmid_stay_idle", PSEL, 0);

        // Completer that never becomes ready.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        PREADY    = 1'b0;
        PRDATA    = 32'hA5A5A5A5;
        tick();
        cmd_valid = 1'b0;
        tick();
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_waiting_psel", PSEL, 1);
            check("to_waiting_rsp", rsp_valid, 0);
        end
        tick();
        check("to_abort_rsp_valid", rsp_valid, 1);
        check("to_abort_rsp_err", rsp_err, 1);
        check("to_abort_rsp_rdata", rsp_rdata, 0);
        check("to_abort_psel", PSEL, 0);
        check("to_abort_penable", PENABLE, 0);
        check("to_abort_ready", cmd_ready, 1);
        tick();
        check("to_pulse_one_cycle", rsp_valid, 0);
`else
        rsp_seen = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (rsp_valid) rsp_seen++;
            check("nto_psel_held", PSEL, 1);
        end
        check("nto_no_rsp", rsp_seen, 0);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        tick();
`endif

        // Continuous requests: one transfer every 3 cycles, address sampled only in IDLE.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        PREADY    = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cmd_addr  = 32'h100 + 32'(k - 1);
            cmd_wdata = 32'h200 + 32'(k - 1);
            tick();
            check("b2b_ready", cmd_ready, (k % 3 == 0) ? 1 : 0);
            check("b2b_rsp_valid", rsp_valid, (k % 3 == 0) ? 1 : 0);
            check("b2b_psel", PSEL, (k % 3 != 0) ? 1 : 0);
            check("b2b_penable", PENABLE, (k % 3 == 2) ? 1 : 0);
            if (k % 3 == 1) check("b2b_setup_paddr", PADDR, 32'h100 + 32'(k - 1));
            if (k % 3 == 2) check("b2b_access_paddr", PADDR, 32'h100 + 32'(k - 2));
            if (k % 3 == 2) check("b2b_access_pwdata", PWDATA, 32'h200 + 32'(k - 2));
        end
        cmd_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
